// File: rtl/cdc_handshake_tx_pkg.sv
// Shared definitions for the SDHC four-phase req/ack crossing.
// The receive-side block imports the same state encoding.
package cdc_handshake_tx_pkg;

  localparam logic [1:0] HS_IDLE = 2'd0;
  localparam logic [1:0] HS_REQ  = 2'd1;
  localparam logic [1:0] HS_REL  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = HS_IDLE,
    ST_REQ  = HS_REQ,
    ST_REL  = HS_REL
  } hs_state_e;

  // Watchdog counter width: enough to hold TIMEOUT, never less than one bit.
  function automatic int unsigned hs_cnt_width(input int unsigned timeout);
    return (timeout == 0) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/cdc_handshake_tx_synch_2.sv
// Two-flop synchronizer. Stages carry no reset: they only ever feed
// logic that ignores them until a transfer is under way.
module synch_2 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Shift the asynchronous input through two stages.
  always_ff @(posedge clk) begin
    meta_q <= d_i;
    sync_q <= meta_q;
  end

  assign q_o = sync_q;

endmodule

// File: rtl/cdc_handshake_tx.sv
// Source-domain end of the four-phase req/ack crossing. Holds a captured
// word on xfer_data, raises xfer_req, then waits for the synchronized
// acknowledge to rise and fall. An optional watchdog abandons requests
// that are never acknowledged.
//
// Input handshake: a word moves when in_valid and in_ready are both 1 at a
// rising clk edge. in_ready is 1 only in IDLE; in_data is ignored otherwise.
module cdc_handshake_tx
  import cdc_handshake_tx_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned TIMEOUT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] xfer_data,
  output logic             xfer_req,
  input  logic             xfer_ack,
  output logic             busy,
  output logic             done,
  output logic             timeout
);

  localparam int unsigned CW = hs_cnt_width(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

  hs_state_e        state_q;
  logic [WIDTH-1:0] data_q;
  logic             req_q;
  logic             done_q;
  logic             timeout_q;
  logic             abandon_q;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;
  logic             ack_s;
  logic             expired;

  // Acknowledge from the far domain, brought into clk.
  synch_2 #(
    .WIDTH (1)
  ) u_ack_sync (
    .clk (clk),
    .d_i (xfer_ack),
    .q_o (ack_s)
  );

  // Saturating increment of the REQ cycle counter and the expiry test.
  always_comb begin
    cnt_d   = cnt_q;
    if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CW'(1);
    end
    expired = (TIMEOUT != 0) && (cnt_q == CNT_LAST);
  end

  // Handshake state machine with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      data_q    <= '0;
      req_q     <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      abandon_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            data_q  <= in_data;
            req_q   <= 1'b1;
            cnt_q   <= '0;
            state_q <= ST_REQ;
          end
        end
        ST_REQ: begin
          cnt_q <= cnt_d;
          // An acknowledge seen in the expiry cycle still counts as success.
          if (ack_s) begin
            req_q   <= 1'b0;
            state_q <= ST_REL;
          end else if (expired) begin
            req_q     <= 1'b0;
            timeout_q <= 1'b1;
            abandon_q <= 1'b1;
            state_q   <= ST_REL;
          end
        end
        ST_REL: begin
          // A late acknowledge after abandonment is absorbed here.
          if (!ack_s) begin
            done_q    <= !abandon_q;
            abandon_q <= 1'b0;
            state_q   <= ST_IDLE;
          end
        end
        default: begin
          req_q   <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign xfer_data = data_q;
  assign xfer_req  = req_q;
  assign done      = done_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Directed bench for cdc_handshake_tx: three instances cover the
// no-watchdog, 16-cycle and 8-cycle watchdog configurations.
module tb_cdc_handshake_tx;

  logic       clk;
  logic       rst_n;
  logic [7:0] in_data   [3];
  logic       in_valid  [3];
  logic       in_ready  [3];
  logic [7:0] xfer_data [3];
  logic       xfer_req  [3];
  logic       xfer_ack  [3];
  logic       busy      [3];
  logic       done      [3];
  logic       timeout   [3];

  int n_checks;
  int n_errors;
  logic [7:0] exp_q[$];

  cdc_handshake_tx #(.WIDTH(8), .TIMEOUT(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .xfer_data(xfer_data[0]), .xfer_req(xfer_req[0]),
    .xfer_ack(xfer_ack[0]), .busy(busy[0]), .done(done[0]), .timeout(timeout[0])
  );

  cdc_handshake_tx #(.WIDTH(8), .TIMEOUT(16)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .xfer_data(xfer_data[1]), .xfer_req(xfer_req[1]),
    .xfer_ack(xfer_ack[1]), .busy(busy[1]), .done(done[1]), .timeout(timeout[1])
  );

  cdc_handshake_tx #(.WIDTH(8), .TIMEOUT(8)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data[2]), .in_valid(in_valid[2]),
    .in_ready(in_ready[2]), .xfer_data(xfer_data[2]), .xfer_req(xfer_req[2]),
    .xfer_ack(xfer_ack[2]), .busy(busy[2]), .done(done[2]), .timeout(timeout[2])
  );

  // Clock and global time guard.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL time_guard: got no finish, expected finish before 200000");
    $fatal(1, "time guard expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full acknowledged handshake. Ack rises ack_dly cycles after the accept
  // edge and drops drop_dly cycles after xfer_req is seen low.
  task automatic xfer(input int d, input logic [7:0] word, input int ack_dly,
                      input int drop_dly, input bit hold);
    logic [7:0] exp;
    int n;
    bit bad;
    bit saw_tmo;
    in_data[d]  = word;
    in_valid[d] = 1'b1;
    exp_q.push_back(word);
    tick();
    if (!hold) in_valid[d] = 1'b0;
    exp = exp_q.pop_front();
    check("acc_req",  xfer_req[d],  1);
    check("acc_data", xfer_data[d], exp);
    check("acc_rdy",  in_ready[d],  0);
    check("acc_done", done[d],      0);
    bad = 0;
    saw_tmo = 0;
    repeat (ack_dly) begin
      tick();
      if (xfer_req[d] !== 1'b1 || xfer_data[d] !== exp) bad = 1;
      if (timeout[d] !== 1'b0) saw_tmo = 1;
    end
    xfer_ack[d] = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
      if (xfer_data[d] !== exp) bad = 1;
      if (timeout[d] !== 1'b0) saw_tmo = 1;
    end while (xfer_req[d] !== 1'b0 && n < 10);
    check("ack_to_req_fall", n, 3);
    check("rel_busy", busy[d], 1);
    repeat (drop_dly) begin
      tick();
      if (xfer_req[d] !== 1'b0 || done[d] !== 1'b0 || in_ready[d] !== 1'b0) bad = 1;
      if (xfer_data[d] !== exp) bad = 1;
      if (timeout[d] !== 1'b0) saw_tmo = 1;
    end
    xfer_ack[d] = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
      if (xfer_data[d] !== exp) bad = 1;
      if (timeout[d] !== 1'b0) saw_tmo = 1;
    end while (done[d] !== 1'b1 && n < 10);
    check("drop_to_done", n, 3);
    check("done_rdy",  in_ready[d],  1);
    check("done_busy", busy[d],      0);
    check("hold_data", xfer_data[d], exp);
    check("stable",    bad,          0);
    check("no_timeout", saw_tmo,     0);
  endtask

  // Watchdog run on the TIMEOUT=16 instance. ack_at > 0 raises the ack
  // during the ack_at-th cycle of xfer_req, too late to be seen in REQ.
  task automatic tmo(input logic [7:0] word, input int ack_at);
    int n;
    bit bad;
    in_data[1]  = word;
    in_valid[1] = 1'b1;
    exp_q.push_back(word);
    tick();
    in_valid[1] = 1'b0;
    check("tmo_acc_data", xfer_data[1], exp_q.pop_front());
    n = 0;
    bad = 0;
    while (xfer_req[1] === 1'b1 && n < 40) begin
      n++;
      if (n == ack_at) xfer_ack[1] = 1'b1;
      if (timeout[1] !== 1'b0 || done[1] !== 1'b0 || xfer_data[1] !== word) bad = 1;
      tick();
    end
    check("tmo_req_cycles", n, 16);
    check("tmo_quiet", bad, 0);
    check("tmo_pulse", timeout[1], 1);
    check("tmo_no_done", done[1], 0);
    check("tmo_busy", busy[1], 1);
    tick();
    check("tmo_pulse_end", timeout[1], 0);
    if (ack_at == 0) begin
      check("tmo_idle", in_ready[1], 1);
      check("tmo_idle_done", done[1], 0);
    end else begin
      check("late_rel", busy[1], 1);
      repeat (2) begin
        tick();
        if (busy[1] !== 1'b1 || done[1] !== 1'b0) bad = 1;
      end
      xfer_ack[1] = 1'b0;
      n = 0;
      do begin
        tick();
        n++;
        if (done[1] !== 1'b0) bad = 1;
      end while (in_ready[1] !== 1'b1 && n < 10);
      check("late_drop_to_idle", n, 3);
      check("late_no_done", done[1], 0);
      check("late_quiet", bad, 0);
      check("late_data", xfer_data[1], word);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_data[i]  = '0;
      in_valid[i] = 1'b0;
      xfer_ack[i] = 1'b0;
    end
    repeat (3) tick();
    for (int i = 0; i < 3; i++) begin
      check("rst_ready", in_ready[i], 1);
      check("rst_busy",  busy[i],     0);
      check("rst_req",   xfer_req[i], 0);
      check("rst_data",  xfer_data[i], 0);
      check("rst_pulses", {done[i], timeout[i]}, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) tick();

    // Single transfer.
    xfer(0, 8'hA5, 3, 3, 0);
    tick();
    check("done_pulse_width", done[0], 0);
    check("idle_data", xfer_data[0], 8'hA5);

    // Back-to-back with in_valid held.
    xfer(0, 8'h01, 1, 1, 1);
    check("b2b_old_data", xfer_data[0], 8'h01);
    xfer(0, 8'h02, 2, 1, 0);
    tick();

    // Watchdog without ack, then a late ack.
    tmo(8'h5A, 0);
    tick();
    tmo(8'h96, 15);
    tick();

    // Ack seen in the expiry cycle of the 8-cycle watchdog.
    xfer(2, 8'hC3, 5, 2, 0);
    tick();

    // Asynchronous reset in the middle of a request.
    in_data[0]  = 8'h77;
    in_valid[0] = 1'b1;
    tick();
    in_valid[0] = 1'b0;
    tick();
    check("pre_rst_req", xfer_req[0], 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_req",   xfer_req[0],  0);
    check("arst_data",  xfer_data[0], 0);
    check("arst_ready", in_ready[0],  1);
    check("arst_busy",  busy[0],      0);
    check("arst_pulses", {done[0], timeout[0]}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    xfer(0, 8'h3C, 3, 3, 0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
